// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS multiply/divide unit writing the HI/LO pair.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract on
//   operand magnitudes. STEP bits are retired per CALC cycle, and a sign fix
//   is applied in a single FIX cycle.
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   flush             abort any in-flight op; start in the same cycle is dropped
//   start, op, opA/B  new request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   busy              high through CALC and FIX; pipeline stalls on it
//   done              one-cycle pulse when hi/lo/div_by_zero are updated
//   hi, lo            product high/low, or remainder/quotient
//   div_by_zero       divide had opB==0; cleared by the next accepted start
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned AW = 2 * WIDTH + 1;

  if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("ex_muldiv_unit: STEP must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;     // {upper W+1 bits, lower W bits}
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             signed_op_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;

  // Scratch for the per-cycle iteration and the sign fix
  logic [AW-1:0]      acc_v;
  logic [WIDTH:0]     part_v;
  logic [2*WIDTH-1:0] prod_v;
  logic [WIDTH-1:0]   quo_v, rem_v;

  // Operand magnitudes; unsigned ops pass straight through
  assign signed_op_c = ~op[0];
  assign mag_a_c = (signed_op_c && opA[WIDTH-1]) ? -opA : opA;
  assign mag_b_c = (signed_op_c && opB[WIDTH-1]) ? -opB : opB;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    acc_v    = acc_q;
    part_v   = '0;
    prod_v   = acc_q[2*WIDTH-1:0];
    quo_v    = acc_q[WIDTH-1:0];
    rem_v    = acc_q[2*WIDTH-1:WIDTH];

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            state_d  = S_CALC;
            cnt_d    = CW'(N);
            is_div_d = op[1];
            neg_a_d  = signed_op_c & opA[WIDTH-1];
            neg_b_d  = signed_op_c & opB[WIDTH-1];
            opnd_d   = op[1] ? mag_b_c : mag_a_c;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier
            acc_d    = {(WIDTH+1)'(0), (op[1] ? mag_a_c : mag_b_c)};
            dbz_d    = 1'b0;
          end
        end
        S_CALC: begin
          for (int unsigned i = 0; i < STEP; i++) begin
            if (is_div_q) begin
              // Remainder stays below the divisor, so the top bit is free to shift into
              acc_v = {acc_v[AW-2:0], 1'b0};
              if (acc_v[AW-1:WIDTH] >= {1'b0, opnd_q}) begin
                acc_v[AW-1:WIDTH] = acc_v[AW-1:WIDTH] - {1'b0, opnd_q};
                acc_v[0] = 1'b1;
              end
            end else begin
              part_v = acc_v[AW-1:WIDTH] + (acc_v[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
              acc_v  = {1'b0, part_v, acc_v[WIDTH-1:1]};
            end
          end
          acc_d = acc_v;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            lo_d = (neg_a_q ^ neg_b_q) ? -quo_v : quo_v;
            // With a zero divisor the remainder ends up as |opA|, so this restores opA
            hi_d = neg_a_q ? -rem_v : rem_v;
            if (opnd_q == '0) begin
              lo_d  = '1;
              dbz_d = 1'b1;
            end
          end else begin
            if (neg_a_q ^ neg_b_q) prod_v = -prod_v;
            hi_d = prod_v[2*WIDTH-1:WIDTH];
            lo_d = prod_v[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit.
//   Instance 0 uses STEP=1 (N=32) and instance 1 uses STEP=4 (N=8), both with WIDTH=32.
//   Expected hi/lo/flag values come from a 64-bit arithmetic model and are queued
//   when an op is issued. They are popped when that instance pulses done.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  typedef struct {
    string          tag;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           dbz;
  } exp_t;

  logic         CLK;
  logic         RST;
  logic         flush [2];
  logic         start [2];
  logic [1:0]   op    [2];
  logic [W-1:0] opA   [2];
  logic [W-1:0] opB   [2];
  logic         busy  [2];
  logic         done  [2];
  logic [W-1:0] hi    [2];
  logic [W-1:0] lo    [2];
  logic         dbz   [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.WIDTH(W), .STEP(1)) dut (
    .CLK(CLK), .RST(RST), .flush(flush[0]), .start(start[0]), .op(op[0]),
    .opA(opA[0]), .opB(opB[0]), .busy(busy[0]), .done(done[0]),
    .hi(hi[0]), .lo(lo[0]), .div_by_zero(dbz[0])
  );

  ex_muldiv_unit #(.WIDTH(W), .STEP(4)) dut4 (
    .CLK(CLK), .RST(RST), .flush(flush[1]), .start(start[1]), .op(op[1]),
    .opA(opA[1]), .opB(opB[1]), .busy(busy[1]), .done(done[1]),
    .hi(hi[1]), .lo(lo[1]), .div_by_zero(dbz[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, p;
    logic [63:0] u;
    e.tag = "";
    e.dbz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin u = {32'd0, a} * {32'd0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      2'b10: begin
        if (b == '0) begin e.lo = '1; e.hi = a; e.dbz = 1'b1; end
        else begin
          p = sa / sb; e.lo = p[31:0];
          p = sa % sb; e.hi = p[31:0];
        end
      end
      default: begin
        if (b == '0) begin e.lo = '1; e.hi = a; e.dbz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  task automatic compare_out(input int s, input exp_t e);
    chk({e.tag, "_hi"},  64'(hi[s]),  64'(e.hi));
    chk({e.tag, "_lo"},  64'(lo[s]),  64'(e.lo));
    chk({e.tag, "_dbz"}, 64'(dbz[s]), 64'(e.dbz));
  endtask

  // Output monitors: each done pulse retires exactly one scoreboard entry
  always @(negedge CLK) begin
    if (done[0]) begin
      if (sb0.size() == 0) chk("spurious_done0", 64'd1, 64'd0);
      else compare_out(0, sb0.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (done[1]) begin
      if (sb1.size() == 0) chk("spurious_done1", 64'd1, 64'd0);
      else compare_out(1, sb1.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called in cycle 0 (just after an edge): queue the expectation and raise start
  task automatic issue(input int s, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    exp_t e;
    e = model(o, a, b);
    e.tag = tag;
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    op[s]    = o;
    opA[s]   = a;
    opB[s]   = b;
    start[s] = 1'b1;
  endtask

  // Issue one op, check the busy profile and the done cycle; returns in the DONE cycle
  task automatic run(input int s, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input string tag);
    int n;
    int dc;
    int berr;
    n    = (s == 0) ? 32 : 8;
    dc   = -1;
    berr = 0;
    issue(s, o, a, b, tag);
    for (int c = 1; c <= n + 10 && dc < 0; c++) begin
      tick();
      if (c == 1) begin
        start[s] = 1'b0;
        chk({tag, "_dbzclr"}, 64'(dbz[s]), 64'd0);
      end
      if (busy[s] !== ((c <= n + 1) ? 1'b1 : 1'b0)) berr++;
      if (done[s] === 1'b1) dc = c;
    end
    chk({tag, "_lat"}, 64'(dc), 64'(n + 2));
    chk({tag, "_busy"}, 64'(berr), 64'd0);
  endtask

  initial begin
    logic [W-1:0] prev_hi, prev_lo;
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    int           nd;

    RST = 1'b1;
    for (int s = 0; s < 2; s++) begin
      flush[s] = 1'b0; start[s] = 1'b0; op[s] = 2'b00; opA[s] = '0; opB[s] = '0;
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_busy", s), 64'(busy[s]), 64'd0);
      chk($sformatf("rst%0d_done", s), 64'(done[s]), 64'd0);
      chk($sformatf("rst%0d_hi", s),   64'(hi[s]),   64'd0);
      chk($sformatf("rst%0d_lo", s),   64'(lo[s]),   64'd0);
      chk($sformatf("rst%0d_dbz", s),  64'(dbz[s]),  64'd0);
    end
    RST = 1'b0;
    tick();

    for (int s = 0; s < 2; s++) begin
      run(s, 2'b00, 32'hFFFFFFFD, 32'h00000007, $sformatf("mult_neg%0d", s));      tick();
      run(s, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, $sformatf("multu_max%0d", s));     tick();
      run(s, 2'b10, 32'hFFFFFFF9, 32'h00000002, $sformatf("div_neg%0d", s));       tick();
      run(s, 2'b10, 32'h80000000, 32'hFFFFFFFF, $sformatf("div_ovf%0d", s));       tick();
      run(s, 2'b11, 32'h0000000A, 32'h00000000, $sformatf("divu_zero%0d", s));     tick();
      run(s, 2'b01, 32'h00000005, 32'h00000006, $sformatf("multu_clr%0d", s));     tick();
      run(s, 2'b10, 32'hFFFFFF00, 32'h00000000, $sformatf("div_zero%0d", s));      tick();
      run(s, 2'b00, 32'h80000000, 32'h80000000, $sformatf("mult_minmin%0d", s));   tick();
      for (int k = 0; k < 8; k++) begin
        ro = 2'($urandom_range(0, 3));
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
        run(s, ro, ra, rb, $sformatf("rnd%0d_%0d", s, k));
        tick();
      end
    end

    // Back-to-back: second start raised during the first op's DONE cycle
    run(0, 2'b00, 32'h00001234, 32'hFFFF0001, "b2b_a");
    run(0, 2'b11, 32'hDEADBEEF, 32'h00000013, "b2b_b");
    tick();

    // Flush in cycle 10 of a MULTU: no done, hi/lo hold
    prev_hi = hi[0];
    prev_lo = lo[0];
    issue(0, 2'b01, 32'h2, 32'h3, "flushed");
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) start[0] = 1'b0;
    end
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk("flush_busy", 64'(busy[0]), 64'd0);
    chk("flush_done", 64'(done[0]), 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done[0] === 1'b1) nd++;
    end
    chk("flush_nodone", 64'(nd), 64'd0);
    chk("flush_hi_hold", 64'(hi[0]), 64'(prev_hi));
    chk("flush_lo_hold", 64'(lo[0]), 64'(prev_lo));
    sb0.delete();

    // start and flush together: start is dropped
    op[0] = 2'b01; opA[0] = 32'h7; opB[0] = 32'h9;
    start[0] = 1'b1;
    flush[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    flush[0] = 1'b0;
    chk("sflush_busy", 64'(busy[0]), 64'd0);
    tick();
    chk("sflush_busy2", 64'(busy[0]), 64'd0);

    // RST during cycle 5 of an op: outputs return to zero, no done
    issue(0, 2'b00, 32'h11111111, 32'h00000003, "reset_abort");
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start[0] = 1'b0;
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_busy", 64'(busy[0]), 64'd0);
    chk("rstmid_done", 64'(done[0]), 64'd0);
    chk("rstmid_hi",   64'(hi[0]),   64'd0);
    chk("rstmid_lo",   64'(lo[0]),   64'd0);
    chk("rstmid_dbz",  64'(dbz[0]),  64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done[0] === 1'b1) nd++;
    end
    chk("rstmid_nodone", 64'(nd), 64'd0);
    sb0.delete();

    chk("sb_left", 64'(sb1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
